// File: rtl/layer_mem_arbiter_pkg.sv
// conv_pkg: shared layer-memory definitions.
//   ADDR_W / DATA_W : default layer-memory address and data widths
//   CSEL_*          : bank select codes for the shared memory port
//   arb_state_t     : arbiter lock state
//   sel_legal()     : true for a bank select that maps to a real bank
package conv_pkg;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 20;
    localparam logic [2:0] CSEL_NONE  = 3'd0;
    localparam logic [2:0] CSEL_L0_K0 = 3'd1;
    localparam logic [2:0] CSEL_L0_K1 = 3'd2;
    localparam logic [2:0] CSEL_L1_K0 = 3'd3;
    localparam logic [2:0] CSEL_L1_K1 = 3'd4;
    localparam logic [2:0] CSEL_FLAT  = 3'd5;
    typedef enum logic {ARB, LOCKED} arb_state_t;
    function automatic logic sel_legal(input logic [2:0] s);
        return s inside {CSEL_L0_K0, CSEL_L0_K1, CSEL_L1_K0, CSEL_L1_K1, CSEL_FLAT};
    endfunction
endpackage

// File: rtl/layer_mem_arbiter_if.sv
// layer_mem_arbiter_if: requester and memory-port bundle of the layer-memory arbiter.
//   requester side : req, we, lock, sel, addr, wdata -> gnt, rvalid, rid, rdata, err
//   memory side    : cwr, crd, csel, caddr_wr, caddr_rd, cdata_wr -> cdata_rd
//   slave  modport : the arbiter
//   master modport : the requesters and the memory
interface layer_mem_arbiter_if #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = conv_pkg::ADDR_W,
    parameter int DATA_W = conv_pkg::DATA_W
);
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        we;
    logic [NREQ-1:0]        lock;
    logic [3*NREQ-1:0]      sel;
    logic [ADDR_W*NREQ-1:0] addr;
    logic [DATA_W*NREQ-1:0] wdata;
    logic [NREQ-1:0]        gnt;
    logic                   rvalid;
    logic [$clog2(NREQ)-1:0] rid;
    logic [DATA_W-1:0]      rdata;
    logic                   err;
    logic                   cwr;
    logic                   crd;
    logic [2:0]             csel;
    logic [ADDR_W-1:0]      caddr_wr;
    logic [ADDR_W-1:0]      caddr_rd;
    logic [DATA_W-1:0]      cdata_wr;
    logic [DATA_W-1:0]      cdata_rd;

    modport slave (
        input  req, we, lock, sel, addr, wdata, cdata_rd,
        output gnt, rvalid, rid, rdata, err, cwr, crd, csel, caddr_wr, caddr_rd, cdata_wr
    );

    modport master (
        output req, we, lock, sel, addr, wdata, cdata_rd,
        input  gnt, rvalid, rid, rdata, err, cwr, crd, csel, caddr_wr, caddr_rd, cdata_wr
    );
endinterface

// File: rtl/layer_mem_arbiter_rr_arbiter.sv
// rr_arbiter: mask-based round-robin priority picker.
//   req : request vector
//   ptr : highest-priority index this cycle
//   gnt : one-hot grant (zero when req is zero)
//   idx : index of the granted bit
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx
);
    logic [N-1:0] masked;
    logic [N-1:0] pool;

    // Requests at or above ptr win; if none, wrap around to the full vector.
    assign masked = req & ~((N'(1) << ptr) - N'(1));
    assign pool   = |masked ? masked : req;
    assign gnt    = pool & (~pool + N'(1));

    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (gnt[i]) idx = ($clog2(N))'(i);
    end
endmodule

// File: rtl/layer_mem_arbiter.sv
// layer_mem_arbiter: round-robin, lockable arbiter for the shared layer-memory port.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of layer_mem_arbiter_if (requester commands in,
//                grant/read return out, registered memory strobes out, cdata_rd in)
module layer_mem_arbiter #(
    parameter int NREQ   = 3,
    parameter int ADDR_W = conv_pkg::ADDR_W,
    parameter int DATA_W = conv_pkg::DATA_W
) (
    input  logic                clk,
    input  logic                reset,
    layer_mem_arbiter_if.slave  bus
);
    import conv_pkg::*;

    localparam int IW = $clog2(NREQ);

    arb_state_t          state;
    logic [IW-1:0]       ptr;
    logic [IW-1:0]       owner;
    logic [NREQ-1:0]     arb_gnt;
    logic [IW-1:0]       arb_idx;
    logic [IW-1:0]       g_idx;
    logic                any;
    logic                g_we;
    logic                g_lock;
    logic                g_legal;
    logic [2:0]          g_sel;
    logic [ADDR_W-1:0]   g_addr;
    logic [DATA_W-1:0]   g_wdata;
    logic                rd_pend;
    logic                rd_ill;
    logic [IW-1:0]       rd_id;

    rr_arbiter #(.N(NREQ)) u_rr (
        .req (bus.req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    always_comb begin
        g_idx   = state == LOCKED ? owner : arb_idx;
        bus.gnt = reset ? '0
                : state == LOCKED ? (bus.req[owner] ? NREQ'(1) << owner : '0)
                : arb_gnt;
        any     = |bus.gnt;
        g_we    = bus.we[g_idx];
        g_lock  = bus.lock[g_idx];
        g_sel   = bus.sel[g_idx*3 +: 3];
        g_addr  = bus.addr[g_idx*ADDR_W +: ADDR_W];
        g_wdata = bus.wdata[g_idx*DATA_W +: DATA_W];
        g_legal = sel_legal(g_sel);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ARB;
            ptr          <= '0;
            owner        <= '0;
            bus.cwr      <= 1'b0;
            bus.crd      <= 1'b0;
            bus.csel     <= CSEL_NONE;
            bus.caddr_wr <= '0;
            bus.caddr_rd <= '0;
            bus.cdata_wr <= '0;
            bus.err      <= 1'b0;
            bus.rvalid   <= 1'b0;
            bus.rid      <= '0;
            bus.rdata    <= '0;
            rd_pend      <= 1'b0;
            rd_ill       <= 1'b0;
            rd_id        <= '0;
        end else begin
            bus.cwr    <= any && g_we && g_legal;
            bus.crd    <= any && !g_we && g_legal;
            // Illegal reads still travel the return pipe so the requester gets an answer.
            rd_pend    <= any && !g_we;
            bus.rvalid <= rd_pend;
            if (any) begin
                rd_id  <= g_idx;
                rd_ill <= !g_legal;
                if (!g_legal) bus.err <= 1'b1;
                if (g_legal) begin
                    bus.csel <= g_sel;
                    if (g_we) begin
                        bus.caddr_wr <= g_addr;
                        bus.cdata_wr <= g_wdata;
                    end else begin
                        bus.caddr_rd <= g_addr;
                    end
                end
                if (g_lock) begin
                    state <= LOCKED;
                    owner <= g_idx;
                end else begin
                    state <= ARB;
                    ptr   <= g_idx == IW'(NREQ - 1) ? '0 : g_idx + 1'b1;
                end
            end
            if (rd_pend) begin
                bus.rid   <= rd_id;
                bus.rdata <= rd_ill ? '0 : bus.cdata_rd;
            end
        end
    end
endmodule

// File: doc/layer_mem_arbiter.md
# layer_mem_arbiter

Round-robin arbiter that shares the single layer-memory port (csel-selected banks: L0 kernel 0/1, L1 kernel 0/1, flatten) among NREQ internal requesters, e.g. the conv writer, the max-pool reader and the flatten writer. Each requester presents one read or write command per grant. The block drives registered memory strobes, addresses and write data, and returns tagged read data. A lock input keeps multi-access sequences atomic, such as the 4-read pooling window.

## Interface
- NREQ, 3, number of requesters (2..8)
- ADDR_W, 12, memory address width
- DATA_W, 20, memory data width
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- req  in  NREQ  per-requester command valid, held until gnt
- we  in  NREQ  1 = write, 0 = read
- lock  in  NREQ  keep the grant on this requester after this command
- sel  in  3*NREQ  bank select per requester; slice i is [3i+2:3i]
- addr  in  ADDR_W*NREQ  address per requester
- wdata  in  DATA_W*NREQ  write data per requester
- gnt  out  NREQ  one-hot, combinational; the command is accepted in this cycle
- rvalid  out  1  read data valid, one-cycle pulse
- rid  out  $clog2(NREQ)  index of the requester that owns rdata
- rdata  out  DATA_W  read data
- err  out  1  sticky: a command with an illegal sel was accepted
- cwr  out  1  memory write strobe
- crd  out  1  memory read strobe
- csel  out  3  memory bank select
- caddr_wr  out  ADDR_W  write address
- caddr_rd  out  ADDR_W  read address
- cdata_wr  out  DATA_W  write data
- cdata_rd  in  DATA_W  read data; valid in the same cycle as crd/caddr_rd

## Operation
- **States:**
  - ARB: grant the first requesting index at or after ptr, wrapping modulo NREQ.
  - LOCKED: grant only the owner. Other requesters wait. No grant is issued while owner req=0.
- **Transitions:**
  - ARB→LOCKED on a grant with lock=1. The owner becomes the granted index.
  - LOCKED→ARB on an owner grant with lock=0.
  - After every grant with lock=0, ptr becomes the granted index+1 (mod NREQ).
  - ptr does not move while LOCKED.
- **Single issue:** at most one gnt bit per cycle. cwr and crd are never high together.
- **Legal sel:** 1..5.
  - A write with legal sel: cwr=1, csel=sel, caddr_wr=addr, cdata_wr=wdata, next cycle.
  - A read with legal sel: crd=1, csel=sel, caddr_rd=addr, next cycle.
- **Illegal sel (0, 6, 7):**
  - The command is still granted, so the requester cannot hang.
  - No strobe is issued. err is set.
  - A read still returns rvalid with rdata=0 and the proper rid.
- **Idle cycles:** cwr=crd=0. csel, addresses and cdata_wr hold their last values.
- **Read return:** the cdata_rd sampled in the crd cycle is registered. rvalid, rid and rdata appear in the following cycle. Read returns stay in grant order; there is no reordering.
- **Reset values:** cwr, crd, csel, caddr_wr, caddr_rd, cdata_wr, rvalid, rid, rdata, err, ptr are all 0. The state is ARB. gnt is 0 while reset is high.
- **Reset mid-operation:** in-flight reads are discarded and no rvalid is issued for them. A held lock is released.

## Timing
- Cycle N: req seen, gnt pulses (combinational from req, lock state and ptr).
- Cycle N+1: memory strobe, address and data are valid (registered at the N→N+1 edge).
- Cycle N+2: rvalid, rid, rdata for a read.
- Read latency from grant is 2 cycles. Write latency is 1 cycle.
- Throughput is one command per cycle, back-to-back, with the pipeline fully overlapped.
- A requester may change its command in cycle N+1 after a grant in cycle N. If req is still high in N+1, that is a new command.
- err rises in cycle N+1 after the illegal grant and holds until reset.

## Structure
- Shared package conv_pkg holds:
  - the CSEL_* constants: NONE=0, L0_K0=1, L0_K1=2, L1_K0=3, L1_K1=4, FLAT=5;
  - ADDR_W and DATA_W;
  - the arbiter state enum {ARB, LOCKED}.
- One sub-module, rr_arbiter: a mask-based round-robin priority picker. Inputs are req and ptr; outputs are a one-hot grant and its index. The lock FSM, command mux, memory registers and read-return pipeline stay in layer_mem_arbiter.

## Test plan
- **Round robin:** req=3'b111 held, we=0, for 6 cycles → gnt sequence 001, 010, 100, 001, 010, 100. Each gnt is followed 2 cycles later by rvalid with rid 0, 1, 2, …
- **Lock:** requester 1 issues 4 reads to sel=1, addr 0x000, 0x001, 0x040, 0x041. lock=1 on the first three, 0 on the last; req0 and req2 are held high throughout. Required: 4 consecutive gnt=010, then gnt=100 (ptr=2). rdata matches the memory model values for those 4 addresses, in order.
- **Write path:** requester 0 writes sel=3, addr 0x3FF, wdata 0x12345 → next cycle cwr=1, crd=0, csel=3, caddr_wr=0x3FF, cdata_wr=0x12345. The following idle cycle shows cwr=0.
- **Illegal sel:** requester 2 reads with sel=6 → gnt, no crd. rvalid 2 cycles later with rid=2 and rdata=0. err=1 and stays 1 through later legal traffic.
- **Reset mid-flight:** assert reset one cycle after a read grant → all outputs 0 immediately, no rvalid afterward. After release, req=3'b110 grants requester 1 first (ptr=0).
